// File: rtl/instr_encoder.sv
// RV32I subset encoder: turns symbolic requests into machine words and streams
// them through a small FIFO into instruction memory at consecutive word addresses.
module instr_encoder #(
   parameter int                DEPTH     = 4,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op_sel,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [12:0]       imm,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              err,
   output logic [15:0]       count
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_SW  = 3'd1,
      OP_ADD = 3'd2,
      OP_SUB = 3'd3,
      OP_AND = 3'd4,
      OP_OR  = 3'd5,
      OP_SLT = 3'd6,
      OP_BEQ = 3'd7
   } op_e;

   logic [31:0]       mem_q [DEPTH];
   logic [PTR_W:0]    wptr_q, wptr_d;
   logic [PTR_W:0]    rptr_q, rptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       count_q, count_d;
   logic              err_q, err_d;

   logic [31:0] enc_word;
   logic        reject;
   logic        empty, full, accept, push, pop;

   always_comb begin
      enc_word = 32'h0;
      reject   = 1'b0;
      case (op_e'(op_sel))
         OP_LW: begin
            enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            reject   = imm[12] != imm[11];
         end
         OP_SW: begin
            enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            reject   = imm[12] != imm[11];
         end
         OP_ADD: enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
         OP_SUB: enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
         OP_AND: enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
         OP_OR:  enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
         OP_SLT: enc_word = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
         OP_BEQ: begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            reject   = imm[0];
         end
         default: enc_word = 32'h0;
      endcase
   end

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty  = wptr_q == rptr_q;
   assign full   = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
   assign accept = in_valid && !full;
   assign push   = accept && !reject;
   assign pop    = !empty && wr_ready;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      addr_d  = addr_q;
      count_d = count_q;
      err_d   = accept && reject;
      if (push) wptr_d = wptr_q + (PTR_W+1)'(1);
      if (pop) begin
         rptr_d  = rptr_q + (PTR_W+1)'(1);
         addr_d  = addr_q + ADDR_W'(4);
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         addr_q  <= BASE_ADDR;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[PTR_W-1:0]] <= enc_word;
   end

   assign in_ready = !full;
   assign wr_en    = !empty;
   assign wr_addr  = addr_q;
   assign wr_data  = mem_q[rptr_q[PTR_W-1:0]];
   assign err      = err_q;
   assign count    = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, FIFO backpressure,
// reject pulses, mid-stream reset and address wrap on a narrow-address instance.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst, rst8;
   logic        in_valid, wr_ready;
   logic [2:0]  op_sel;
   logic [4:0]  rd, rs1, rs2;
   logic [12:0] imm;

   logic        in_ready, wr_en, err;
   logic [31:0] wr_addr, wr_data;
   logic [15:0] count;

   logic        in_ready8, wr_en8, err8;
   logic [7:0]  wr_addr8;
   logic [31:0] wr_data8;
   logic [15:0] count8;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] log_addr[$], log_data[$];
   logic [31:0] log_addr8[$];

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .err(err), .count(count)
   );

   instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(8'hFC)) dut8 (
      .clk(clk), .rst(rst8), .in_valid(in_valid), .in_ready(in_ready8),
      .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .wr_en(wr_en8), .wr_ready(wr_ready), .wr_addr(wr_addr8), .wr_data(wr_data8),
      .err(err8), .count(count8)
   );

   // Inputs change on the falling edge; 1 ns later they and the registered
   // outputs are stable until the next rising edge, so a handshake seen here
   // is the one the rising edge will complete.
   always begin
      @(negedge clk);
      #1;
      if (!rst && wr_en && wr_ready) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
      end
      if (!rst8 && wr_en8 && wr_ready) log_addr8.push_back({24'h0, wr_addr8});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [12:0] im);
      in_valid = 1'b1;
      op_sel   = op;
      rd       = d;
      rs1      = s1;
      rs2      = s2;
      imm      = im;
   endtask

   task automatic push1(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [12:0] im);
      drive(op, d, s1, s2, im);
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_log(input string tag, input logic [31:0] ea[$], input logic [31:0] ed[$]);
      check({tag, "_nwr"}, log_addr.size(), ea.size());
      for (int i = 0; i < ea.size() && i < log_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), log_addr[i], ea[i]);
         check($sformatf("%s_data%0d", tag, i), log_data[i], ed[i]);
      end
      log_addr.delete();
      log_data.delete();
   endtask

   initial begin
      logic [31:0] words[4];
      words = '{32'h003100B3, 32'h403100B3, 32'h00C5E533, 32'h003120B3};

      rst = 1'b1; rst8 = 1'b1; in_valid = 1'b0; wr_ready = 1'b1;
      op_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      repeat (2) step();
      rst = 1'b0;

      check("rst_wr_en", wr_en, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_count", count, 0);
      check("rst_err", err, 0);
      check("rst_addr", wr_addr, 0);

      // single lw: visible next cycle, popped on the following edge
      push1(3'd0, 5'd5, 5'd1, 5'd0, 13'd8);
      check("lw_wr_en", wr_en, 1);
      check("lw_addr", wr_addr, 0);
      check("lw_data", wr_data, 32'h0080A283);
      step();
      check("lw_count", count, 1);
      check("lw_empty", wr_en, 0);
      log_addr.delete(); log_data.delete();

      // back-to-back sw, sub, and
      drive(3'd1, 5'd0, 5'd2, 5'd6, 13'd12); step();
      drive(3'd3, 5'd3, 5'd1, 5'd2, 13'd0);  step();
      drive(3'd4, 5'd7, 5'd8, 5'd9, 13'd0);  step();
      in_valid = 1'b0;
      repeat (4) step();
      check_log("b2b", '{32'd4, 32'd8, 32'd12}, '{32'h00612623, 32'h402081B3, 32'h009473B3});
      check("b2b_count", count, 4);

      // legal beq, then rejected beq (odd offset), rejected lw, legal negative lw
      push1(3'd7, 5'd0, 5'd1, 5'd2, 13'h1FF8);
      drive(3'd7, 5'd0, 5'd1, 5'd2, 13'd3); step();
      in_valid = 1'b0;
      check("beq_bad_err", err, 1);
      check("beq_bad_wr_en", wr_en, 0);
      step();
      check("beq_bad_err_clr", err, 0);
      check("beq_bad_count", count, 5);
      push1(3'd0, 5'd1, 5'd2, 5'd0, 13'h0800);
      check("lw_range_err", err, 1);
      check("lw_range_wr_en", wr_en, 0);
      push1(3'd0, 5'd1, 5'd2, 5'd0, 13'h1FFC);
      check("lw_neg_err", err, 0);
      repeat (2) step();
      check_log("br", '{32'd16, 32'd20}, '{32'hFE208CE3, 32'hFFC12083});
      check("br_count", count, 6);

      // backpressure: fill the FIFO, fifth request must be stalled
      wr_ready = 1'b0;
      drive(3'd2, 5'd1, 5'd2, 5'd3, 13'd0);
      check("full_rdy0", in_ready, 1);
      step();
      drive(3'd3, 5'd1, 5'd2, 5'd3, 13'd0);
      check("full_rdy1", in_ready, 1);
      check("full_hold1", wr_data, words[0]);
      step();
      drive(3'd5, 5'd10, 5'd11, 5'd12, 13'd0);
      check("full_rdy2", in_ready, 1);
      step();
      drive(3'd6, 5'd1, 5'd2, 5'd3, 13'd0);
      check("full_rdy3", in_ready, 1);
      step();
      drive(3'd4, 5'd7, 5'd8, 5'd9, 13'd0);
      check("full_rdy4", in_ready, 0);
      check("full_hold4", wr_data, words[0]);
      check("full_addr_hold", wr_addr, 24);
      step();
      in_valid = 1'b0;
      check("full_stall_rdy", in_ready, 0);
      check("full_hold5", wr_data, words[0]);
      wr_ready = 1'b1;
      step();
      check("drain_rdy", in_ready, 1);
      repeat (4) step();
      check_log("drain", '{32'd24, 32'd28, 32'd32, 32'd36}, '{words[0], words[1], words[2], words[3]});
      check("drain_count", count, 10);

      // reset mid-drain discards buffered words
      wr_ready = 1'b0;
      push1(3'd0, 5'd5, 5'd1, 5'd0, 13'd8);
      push1(3'd0, 5'd5, 5'd1, 5'd0, 13'd8);
      push1(3'd0, 5'd5, 5'd1, 5'd0, 13'd8);
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      log_addr.delete(); log_data.delete();
      check("mid_rst_wr_en", wr_en, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_addr", wr_addr, 0);
      wr_ready = 1'b1;
      push1(3'd2, 5'd1, 5'd2, 5'd3, 13'd0);
      repeat (2) step();
      check_log("post_rst", '{32'd0}, '{words[0]});
      check("post_rst_count", count, 1);

      // narrow-address instance wraps 0xFC -> 0x00
      rst8 = 1'b0;
      check("w8_addr0", {24'h0, wr_addr8}, 32'hFC);
      push1(3'd0, 5'd5, 5'd1, 5'd0, 13'd8);
      push1(3'd4, 5'd7, 5'd8, 5'd9, 13'd0);
      check("w8_data", wr_data8, 32'h009473B3);
      repeat (2) step();
      check("w8_nwr", log_addr8.size(), 2);
      if (log_addr8.size() >= 2) begin
         check("w8_addr_a", log_addr8[0], 32'hFC);
         check("w8_addr_b", log_addr8[1], 32'h00);
      end
      check("w8_count", count8, 2);
      check("w8_addr_next", {24'h0, wr_addr8}, 32'h04);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoding counterpart to the control decoder: turns symbolic instruction requests into 32-bit RV32I machine words.
- Covers exactly the supported subset: lw, sw, add, sub, and, or, slt, beq.
- Buffers encoded words in a small FIFO and streams them into instruction memory through a write port with backpressure.
- Used to load test programs and for self-checking benches of the decode path.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 32, instruction-memory byte address width
BASE_ADDR, 0, byte address of first written word (multiple of 4)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  request present
in_ready  out  1  request can be accepted this cycle
op_sel  in  3  0 lw, 1 sw, 2 add, 3 sub, 4 and, 5 or, 6 slt, 7 beq
rd  in  5  destination register (ignored for sw/beq)
rs1  in  5  source register 1
rs2  in  5  source register 2 (ignored for lw)
imm  in  13  signed immediate; lw/sw use imm[11:0]; beq uses imm[12:1]
wr_en  out  1  valid word on wr_addr/wr_data
wr_ready  in  1  memory accepts word this cycle
wr_addr  out  ADDR_W  byte address of head word
wr_data  out  32  encoded head word
err  out  1  one-cycle pulse: rejected request
count  out  16  words written since reset

Behaviour:
- Reset (clk edge with rst=1): FIFO emptied, write pointer = BASE_ADDR, count=0, err=0. Consequently wr_en=0 and in_ready=1 in the cycle after reset. Reset mid-stream discards buffered words without writing them.
- Accept: in_valid && in_ready at an edge. in_ready = !full; it does not depend on wr_ready, so there is no same-cycle bypass when full.
- Encoding is combinational from the inputs; the result is pushed on accept.
- lw: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}
- sw: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}
- R-type: {f7, rs2, rs1, f3, rd, 7'b0110011}
  - add: f3 000, f7 0000000
  - sub: f3 000, f7 0100000
  - and: f3 111, f7 0000000
  - or: f3 110, f7 0000000
  - slt: f3 010, f7 0000000
- beq: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}
- Rejection: beq with imm[0]=1, or lw/sw with imm[12]!=imm[11] (out of range).
  - The request is still accepted (handshake completes) but nothing is pushed.
  - err pulses high for exactly the cycle after the accept edge.
- Latency: an accepted legal request is visible on wr_en/wr_data in the next cycle if the FIFO was empty.
- Output: wr_en = !empty; wr_data = head entry.
- Pop: wr_en && wr_ready at an edge. On pop: wr_addr advances by 4 (wraps modulo 2^ADDR_W) and count increments (wraps at 2^16).
- wr_addr/wr_data are held stable while wr_en && !wr_ready.
- Simultaneous push and pop when neither empty nor full: occupancy unchanged, FIFO order preserved.
- Full: in_ready=0; a pop that edge raises in_ready the next cycle.
- Empty with simultaneous push: the word appears next cycle; no combinational bypass to wr_data.
- Outputs are driven from registers only (FIFO storage, pointers, err, count); no combinational path from in_* to wr_*.

Test Plan:
- Reset, then lw rd=5 rs1=1 imm=8, wr_ready=1 -> next cycle: wr_en=1, wr_addr=BASE_ADDR, wr_data=0x0080A283; count=1 after the pop edge.
- Back-to-back sw rs2=6 rs1=2 imm=12, then sub rd=3 rs1=1 rs2=2, then and rd=7 rs1=8 rs2=9 -> words 0x00612623, 0x402081B3, 0x009473B3 at addresses BASE, BASE+4, BASE+8.
- beq rs1=1 rs2=2 imm=-8 (13'h1FF8) -> 0xFE208CE3. beq imm=3 -> err pulse for 1 cycle, no word written, count unchanged.
- wr_ready=0, push DEPTH+1 requests -> in_ready=0 after DEPTH accepts. wr_data holds the first word throughout. Releasing wr_ready drains in order, with addresses incrementing by 4.
- Mid-drain, assert rst for one edge -> wr_en=0, count=0. Next legal push is written at BASE_ADDR.
- BASE_ADDR=2^ADDR_W-4 with ADDR_W=8 and two writes -> addresses 0xFC then 0x00.
